// File: rtl/pmem_line_responder.sv
// Fixed-latency 128-bit line store answering the cache pmem read/write handshake.
// Define PMEM_NEXTLINE_BUF_EN to add a one-entry next-line read buffer (latency-1 hits).
module pmem_line_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LINE_WIDTH = 128,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic                  pmem_resp,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_err
);
  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [1:0]            req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic [1:0]            req_now;
  logic                  store_we;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LINE_WIDTH-1:0] store_q [DEPTH];
  logic [LINE_WIDTH-1:0] rd_data_q;
  logic [LINE_WIDTH-1:0] resp_data;

`ifdef PMEM_NEXTLINE_BUF_EN
  logic                  buf_valid_q;
  logic                  fill_q;
  logic                  hit_q, hit_d;
  logic                  buf_hit;
  logic [ADDR_WIDTH-1:0] buf_addr_q;
  logic [LINE_WIDTH-1:0] buf_data_q;
`endif

  assign req_now  = {pmem_read, pmem_write};
  assign store_we = (state_q == S_RESP) && op_wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef PMEM_NEXTLINE_BUF_EN
    hit_d   = hit_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_now != 2'b00) begin
          op_wr_d = pmem_write;
          req_d   = req_now;
          addr_d  = pmem_address;
          wdata_d = pmem_wdata;
          cnt_d   = CNT_LOAD;
          state_d = S_BUSY;
          // Simultaneous read and write resolves to a write but is flagged.
          if (req_now == 2'b11) err_d = 1'b1;
`ifdef PMEM_NEXTLINE_BUF_EN
          hit_d = buf_hit;
          if (buf_hit) begin
            state_d = S_RESP;
            cnt_d   = '0;
          end
`endif
        end
      end
      S_BUSY: begin
        if (req_now == 2'b00) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (req_now != req_q) err_d = 1'b1;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      req_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

`ifdef PMEM_NEXTLINE_BUF_EN
  assign buf_hit   = buf_valid_q && (req_now == 2'b10) && (pmem_address == buf_addr_q);
  // While in RESP the read port looks one line ahead to feed the buffer.
  assign rd_addr   = (state_q == S_RESP) ? addr_q + ADDR_WIDTH'(1) : addr_q;
  assign resp_data = hit_q ? buf_data_q : rd_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      fill_q      <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      hit_q  <= hit_d;
      fill_q <= 1'b0;
      if ((state_q == S_RESP) && !op_wr_q) begin
        buf_valid_q <= 1'b1;
        buf_addr_q  <= addr_q + ADDR_WIDTH'(1);
        fill_q      <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_q) begin
      buf_data_q <= rd_data_q;
    end else if (store_we && buf_valid_q && (addr_q == buf_addr_q)) begin
      buf_data_q <= wdata_q;
    end
  end
`else
  assign rd_addr   = addr_q;
  assign resp_data = rd_data_q;
`endif

  // Store has no reset so it maps onto block RAM with a registered read port.
  always_ff @(posedge clk) begin
    if (store_we) store_q[addr_q] <= wdata_q;
    rd_data_q <= store_q[rd_addr];
  end

  assign pmem_resp  = (state_q == S_RESP);
  assign pmem_rdata = (pmem_resp && !op_wr_q) ? resp_data : '0;
  assign pmem_err   = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Randomized self-checking bench for pmem_line_responder against a transaction-level model.
module tb_pmem_line_responder;
  localparam int AW  = 12;
  localparam int LW  = 128;
  localparam int LAT = 4;
`ifdef PMEM_NEXTLINE_BUF_EN
  localparam bit NL_EN = 1'b1;
`else
  localparam bit NL_EN = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_err;

  pmem_line_responder #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .pmem_err     (pmem_err)
  );

  localparam logic [LW-1:0] DEADBEEF = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [LW-1:0] L30      = 128'h3030_3030_0000_0000_0000_0000_3030_3030;
  localparam logic [LW-1:0] L000     = 128'h0000_AAAA_0000_AAAA_0000_AAAA_0000_AAAA;
  localparam logic [LW-1:0] N001     = 128'h0001_5555_0001_5555_0001_5555_0001_5555;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [LW-1:0] ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] known[$];
  bit            model_err = 1'b0;
  bit            exp_valid = 1'b0;
  bit            exp_read  = 1'b0;
  int            exp_cyc   = 0;
  logic [LW-1:0] exp_data  = '0;
  bit            buf_valid = 1'b0;
  logic [AW-1:0] buf_addr  = '0;
  int            last_issue_cyc = 0;
  int            last_resp_cyc  = -1;
  logic [LW-1:0] last_resp_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Per-cycle compare against the model's expectation for the current transaction.
  always @(negedge clk) begin
    logic exp_resp;
    exp_resp = exp_valid && (cyc == exp_cyc);
    chk("resp", {127'b0, pmem_resp}, {127'b0, exp_resp});
    chk("rdata", pmem_rdata, (exp_resp && exp_read) ? exp_data : '0);
    chk("err", {127'b0, pmem_err}, {127'b0, model_err});
    if (pmem_resp === 1'b1) begin
      last_resp_cyc  = cyc;
      last_resp_data = pmem_rdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    repeat (n) step();
  endtask

  // One request: response expected LAT cycles after the cycle it is presented (1 on a buffer hit).
  task automatic txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                     input logic [LW-1:0] wd, input int drop_d, input bit flip);
    bit hit;
    int lat;
    hit = NL_EN && rd && !wr && buf_valid && (addr == buf_addr);
    lat = hit ? 1 : LAT;
    pmem_read      = rd;
    pmem_write     = wr;
    pmem_address   = addr;
    pmem_wdata     = wd;
    exp_read       = rd && !wr;
    exp_data       = ref_mem[addr];
    exp_cyc        = cyc + lat;
    exp_valid      = 1'b1;
    last_issue_cyc = cyc;
    step();
    if (rd && wr) model_err = 1'b1;
    pmem_address = AW'($urandom());
    pmem_wdata   = rnd_line();
    if (drop_d >= 0 && !hit) begin
      repeat (drop_d) step();
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      exp_valid  = 1'b0;
      step();
      return;
    end
    if (flip && !hit && !(rd && wr)) begin
      pmem_read  = 1'b1;
      pmem_write = 1'b1;
      step();
      model_err = 1'b1;
    end
    while (cyc < exp_cyc) step();
    step();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    exp_valid  = 1'b0;
    if (wr) begin
      ref_mem[addr] = wd;
    end else begin
      buf_valid = 1'b1;
      buf_addr  = addr + AW'(1);
    end
  endtask

  initial begin
    logic [AW-1:0] pre [5];
    logic [AW-1:0] ra;
    int            kind;
    int            first;
    bit            rw;

    pre = '{12'h010, 12'h011, 12'h020, 12'hFFF, 12'h001};
    reset_n      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp", {127'b0, pmem_resp}, 128'd0);
    chk("rst_rdata", pmem_rdata, 128'd0);
    chk("rst_err", {127'b0, pmem_err}, 128'd0);
    #1 reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      txn(1'b0, 1'b1, pre[i], rnd_line(), -1, 1'b0);
      known.push_back(pre[i]);
    end
    txn(1'b0, 1'b1, 12'h030, L30, -1, 1'b0);
    known.push_back(12'h030);
    txn(1'b0, 1'b1, 12'h000, L000, -1, 1'b0);
    known.push_back(12'h000);
    for (int i = 0; i < 12; i++) begin
      ra = AW'($urandom());
      txn(1'b0, 1'b1, ra, rnd_line(), -1, 1'b0);
      known.push_back(ra);
      idle($urandom_range(0, 1));
    end

    // Write then read back 0x123.
    idle(1);
    txn(1'b0, 1'b1, 12'h123, DEADBEEF, -1, 1'b0);
    chk("t1_wr_lat", 128'(last_resp_cyc - last_issue_cyc), 128'(LAT));
    idle(1);
    txn(1'b1, 1'b0, 12'h123, rnd_line(), -1, 1'b0);
    chk("t1_rd_lat", 128'(last_resp_cyc - last_issue_cyc), 128'(LAT));
    chk("t1_rd_data", last_resp_data, DEADBEEF);
    known.push_back(12'h123);

    // Back-to-back reads, second request presented in the idle cycle.
    idle(2);
    txn(1'b1, 1'b0, 12'h010, rnd_line(), -1, 1'b0);
    first = last_resp_cyc;
    txn(1'b1, 1'b0, 12'h011, rnd_line(), -1, 1'b0);
    chk("t2_spacing", 128'(last_resp_cyc - first), NL_EN ? 128'd2 : 128'(LAT + 1));
    chk("t2_err", {127'b0, pmem_err}, 128'd0);

    // Write dropped after two busy cycles: no response, old data survives.
    idle(1);
    txn(1'b0, 1'b1, 12'h030, rnd_line(), 2, 1'b0);
    chk("t4_noresp", {127'b0, last_resp_cyc < last_issue_cyc}, 128'd1);
    idle(1);
    txn(1'b1, 1'b0, 12'h030, rnd_line(), -1, 1'b0);
    chk("t4_old_data", last_resp_data, L30);

    // Read and write together: committed as a write, error latched.
    idle(1);
    txn(1'b1, 1'b1, 12'h020, '1, -1, 1'b0);
    chk("t3_err_set", {127'b0, pmem_err}, 128'd1);
    idle(2);
    txn(1'b1, 1'b0, 12'h020, rnd_line(), -1, 1'b0);
    chk("t3_rd_ones", last_resp_data, {LW{1'b1}});
    chk("t3_err_sticky", {127'b0, pmem_err}, 128'd1);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      ra   = known[$urandom_range(0, known.size() - 1)];
      case (kind)
        0, 1, 2, 3: txn(1'b1, 1'b0, ra, rnd_line(), -1, 1'b0);
        4, 5:       txn(1'b0, 1'b1, ra, rnd_line(), -1, 1'b0);
        6: begin
          ra = AW'($urandom());
          txn(1'b0, 1'b1, ra, rnd_line(), -1, 1'b0);
          known.push_back(ra);
        end
        7: begin
          rw = 1'($urandom_range(0, 1));
          txn(rw, !rw, ra, rnd_line(), $urandom_range(0, LAT - 2), 1'b0);
        end
        8:       txn(1'b1, 1'b0, ra, rnd_line(), -1, 1'b1);
        default: txn(1'b1, 1'b1, ra, rnd_line(), -1, 1'b0);
      endcase
      idle($urandom_range(0, 2));
    end

    // Reset in the middle of a busy write: outputs clear at once, write is lost.
    idle(1);
    ra           = 12'h010;
    pmem_read    = 1'b0;
    pmem_write   = 1'b1;
    pmem_address = ra;
    pmem_wdata   = rnd_line();
    exp_read     = 1'b0;
    exp_cyc      = cyc + LAT;
    exp_valid    = 1'b1;
    step();
    step();
    chk("t5_err_before", {127'b0, pmem_err}, 128'd1);
    #2;
    reset_n    = 1'b0;
    exp_valid  = 1'b0;
    model_err  = 1'b0;
    buf_valid  = 1'b0;
    pmem_write = 1'b0;
    #1;
    chk("t5_async_resp", {127'b0, pmem_resp}, 128'd0);
    chk("t5_async_rdata", pmem_rdata, 128'd0);
    chk("t5_async_err", {127'b0, pmem_err}, 128'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    step();
    txn(1'b1, 1'b0, ra, rnd_line(), -1, 1'b0);
    chk("t5_rd_lat", 128'(last_resp_cyc - last_issue_cyc), 128'(LAT));

    // Address wrap and next-line behaviour.
    idle(1);
    txn(1'b1, 1'b0, 12'hFFF, rnd_line(), -1, 1'b0);
    chk("nl_lat_fff", 128'(last_resp_cyc - last_issue_cyc), 128'(LAT));
    txn(1'b1, 1'b0, 12'h000, rnd_line(), -1, 1'b0);
    chk("nl_lat_000", 128'(last_resp_cyc - last_issue_cyc), NL_EN ? 128'd1 : 128'(LAT));
    chk("nl_data_000", last_resp_data, L000);
    idle(1);
    txn(1'b0, 1'b1, 12'h001, N001, -1, 1'b0);
    idle(1);
    txn(1'b1, 1'b0, 12'h001, rnd_line(), -1, 1'b0);
    chk("nl_lat_001", 128'(last_resp_cyc - last_issue_cyc), NL_EN ? 128'd1 : 128'(LAT));
    chk("nl_data_001", last_resp_data, N001);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
